// File: rtl/lcb_responder.sv
// LCB channel responder: receives a 4-byte request over a half-duplex UART link,
// validates it, then turns the line around and answers with address, command,
// RESP_BYTES payload bytes fetched from an external 1-cycle-latency memory, and
// an XOR checksum.
module lcb_responder #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  DEV_ADDR     = 8'hA5,
    parameter int unsigned RESP_BYTES   = 4,
    parameter int unsigned TURN_CLKS    = 64,
    parameter int unsigned GAP_CLKS     = 320
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    output logic       dirTX,
    output logic       dirRX,
    output logic [7:0] dataAddr,
    output logic       dataRd,
    input  logic [7:0] dataIn,
    output logic       reqValid,
    output logic [7:0] reqCmd,
    output logic [7:0] reqParam,
    output logic       errFrame,
    output logic       errSum,
    output logic       busy
);

    localparam int unsigned RX_CW     = $clog2(CLKS_PER_BIT);
    localparam int unsigned TX_MAX    = (TURN_CLKS > CLKS_PER_BIT) ? TURN_CLKS : CLKS_PER_BIT;
    localparam int unsigned TX_CW     = $clog2(TX_MAX);
    localparam int unsigned GAP_CW    = $clog2(GAP_CLKS);
    localparam int unsigned NUM_BYTES = RESP_BYTES + 3;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [2:0] {TxIdle, TxTurn, TxGuard, TxSend, TxHold} tx_state_e;

    rx_state_e          rx_state;
    logic               rx_meta, rx_sync, rx_prev;
    logic [RX_CW-1:0]   rx_cnt;
    logic [2:0]         rx_bit;
    logic [7:0]         rx_shift;
    logic [1:0]         pkt_idx;
    logic [7:0]         b0, b1, b2;
    logic [GAP_CW-1:0]  gap_cnt;

    tx_state_e          tx_state;
    logic [TX_CW-1:0]   tx_cnt;
    logic [3:0]         bit_idx;
    logic [4:0]         byte_idx;
    logic [7:0]         tx_byte, nxt_byte, csum;
    logic               rd_pend;

    logic stop_sample, addr_ok, sum_ok, accept, bit_end;
    logic [7:0] load_val;

    // Request decode at the stop-bit sample of the fourth byte; rx_shift holds the checksum byte
    always_comb begin
        stop_sample = (rx_state == RxStop) && (rx_cnt == RX_CW'(CLKS_PER_BIT - 1)) && !dirRX;
        addr_ok     = (b0 == DEV_ADDR);
        sum_ok      = (rx_shift == (b0 ^ b1 ^ b2));
        accept      = stop_sample && rx_sync && (pkt_idx == 2'd3) && addr_ok && sum_ok && !busy;
        bit_end     = (tx_cnt == TX_CW'(CLKS_PER_BIT - 1));
        load_val    = (byte_idx == 5'(NUM_BYTES - 2)) ? csum : nxt_byte;
    end

    // Receiver: synchroniser, byte deserialiser, packet assembly and request outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RxIdle;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            pkt_idx  <= '0;
            b0       <= '0;
            b1       <= '0;
            b2       <= '0;
            gap_cnt  <= '0;
            reqValid <= 1'b0;
            reqCmd   <= '0;
            reqParam <= '0;
            errFrame <= 1'b0;
            errSum   <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            reqValid <= accept;
            errFrame <= 1'b0;
            errSum   <= 1'b0;
            if (accept) begin
                reqCmd   <= b1;
                reqParam <= b2;
            end
            if (dirRX) begin
                // Our own transmission owns the bus; forget any partial request
                rx_state <= RxIdle;
                pkt_idx  <= '0;
                gap_cnt  <= '0;
            end else begin
                unique case (rx_state)
                    RxIdle: begin
                        if (pkt_idx != 2'd0) begin
                            if (gap_cnt == GAP_CW'(GAP_CLKS - 1)) begin
                                pkt_idx <= '0;
                                gap_cnt <= '0;
                            end else begin
                                gap_cnt <= gap_cnt + 1'b1;
                            end
                        end
                        if (rx_prev && !rx_sync) begin
                            rx_state <= RxStart;
                            rx_cnt   <= '0;
                        end
                    end
                    RxStart: begin
                        if (rx_cnt == RX_CW'(CLKS_PER_BIT / 2 - 1)) begin
                            rx_cnt   <= '0;
                            rx_bit   <= '0;
                            rx_state <= rx_sync ? RxIdle : RxData;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                    RxData: begin
                        if (rx_cnt == RX_CW'(CLKS_PER_BIT - 1)) begin
                            rx_cnt   <= '0;
                            rx_shift <= {rx_sync, rx_shift[7:1]};
                            rx_bit   <= rx_bit + 1'b1;
                            if (rx_bit == 3'd7) rx_state <= RxStop;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                    RxStop: begin
                        if (stop_sample) begin
                            rx_state <= RxIdle;
                            gap_cnt  <= '0;
                            if (!rx_sync) begin
                                errFrame <= 1'b1;
                                pkt_idx  <= '0;
                            end else begin
                                if (pkt_idx == 2'd0) b0 <= rx_shift;
                                if (pkt_idx == 2'd1) b1 <= rx_shift;
                                if (pkt_idx == 2'd2) b2 <= rx_shift;
                                // Index wraps 3 -> 0 after the checksum byte
                                pkt_idx <= pkt_idx + 2'd1;
                                if (pkt_idx == 2'd3) errSum <= addr_ok && !sum_ok && !busy;
                            end
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Responder: turnaround delay, guard bit, serialised response, hold bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TxIdle;
            tx_cnt   <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx_byte  <= '0;
            nxt_byte <= '0;
            csum     <= '0;
            rd_pend  <= 1'b0;
            tx       <= 1'b1;
            dirTX    <= 1'b0;
            dirRX    <= 1'b0;
            dataRd   <= 1'b0;
            dataAddr <= '0;
            busy     <= 1'b0;
        end else begin
            dataRd  <= 1'b0;
            rd_pend <= dataRd;
            if (rd_pend) nxt_byte <= dataIn;
            case (tx_state)
                TxIdle: begin
                    if (accept) begin
                        busy     <= 1'b1;
                        tx_cnt   <= '0;
                        tx_state <= TxTurn;
                    end
                end
                TxTurn: begin
                    if (tx_cnt == TX_CW'(TURN_CLKS - 1)) begin
                        dirTX    <= 1'b1;
                        dirRX    <= 1'b1;
                        tx_cnt   <= '0;
                        tx_state <= TxGuard;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TxGuard: begin
                    if (bit_end) begin
                        tx       <= 1'b0;
                        tx_byte  <= DEV_ADDR;
                        csum     <= DEV_ADDR;
                        nxt_byte <= reqCmd;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                        tx_cnt   <= '0;
                        tx_state <= TxSend;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TxSend: begin
                    if (!bit_end) begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end else begin
                        tx_cnt <= '0;
                        if (bit_idx <= 4'd7) begin
                            tx      <= tx_byte[bit_idx[2:0]];
                            bit_idx <= bit_idx + 4'd1;
                        end else if (bit_idx == 4'd8) begin
                            tx      <= 1'b1;
                            bit_idx <= 4'd9;
                        end else if (byte_idx == 5'(NUM_BYTES - 1)) begin
                            tx_state <= TxHold;
                        end else begin
                            // Start the next byte and prefetch the payload byte after it
                            byte_idx <= byte_idx + 5'd1;
                            tx       <= 1'b0;
                            tx_byte  <= load_val;
                            csum     <= csum ^ load_val;
                            bit_idx  <= '0;
                            if (byte_idx < 5'(RESP_BYTES)) begin
                                dataRd   <= 1'b1;
                                dataAddr <= reqParam + {3'b000, byte_idx};
                            end
                        end
                    end
                end
                TxHold: begin
                    if (bit_end) begin
                        dirTX    <= 1'b0;
                        dirRX    <= 1'b0;
                        busy     <= 1'b0;
                        tx_state <= TxIdle;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TxIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lcb_responder.sv
// Randomised bench for lcb_responder with a byte-level reference model of the response.
module tb_lcb_responder;

    localparam int CPB = 16;
    localparam int RB  = 4;
    localparam int NB  = RB + 3;

    logic       clk = 1'b0;
    logic       rst, rx;
    logic       tx, dirTX, dirRX, dataRd, reqValid, errFrame, errSum, busy;
    logic [7:0] dataAddr, dataIn, reqCmd, reqParam;

    lcb_responder #(
        .CLKS_PER_BIT(CPB),
        .DEV_ADDR    (8'hA5),
        .RESP_BYTES  (RB),
        .TURN_CLKS   (64),
        .GAP_CLKS    (320)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .tx      (tx),
        .dirTX   (dirTX),
        .dirRX   (dirRX),
        .dataAddr(dataAddr),
        .dataRd  (dataRd),
        .dataIn  (dataIn),
        .reqValid(reqValid),
        .reqCmd  (reqCmd),
        .reqParam(reqParam),
        .errFrame(errFrame),
        .errSum  (errSum),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Payload memory: registered read, data valid the cycle after dataRd
    logic [7:0] mem [256];
    initial forever begin
        @(posedge clk);
        if (dataRd) dataIn <= mem[dataAddr];
    end

    int unsigned cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int          checks = 0, failures = 0;
    int          rv_cnt, fe_cnt, es_cnt, tx_falls;
    int unsigned rv_cyc, rise_cyc, fall_cyc;
    bit          rise_seen, fall_seen;
    logic [7:0]  addr_q[$];
    logic [7:0]  txq[$];
    logic [7:0]  exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output event monitor
    initial begin : mon
        logic dir_prev, tx_prev;
        dir_prev = 1'b0;
        tx_prev  = 1'b1;
        forever begin
            @(negedge clk);
            if (reqValid) begin rv_cnt++; rv_cyc = cyc; end
            if (errFrame) fe_cnt++;
            if (errSum) es_cnt++;
            if (dataRd) addr_q.push_back(dataAddr);
            if (tx_prev && !tx) tx_falls++;
            if (dirTX && !dir_prev) begin rise_seen = 1; rise_cyc = cyc; end
            if (!dirTX && dir_prev && !rst) begin fall_seen = 1; fall_cyc = cyc; end
            dir_prev = dirTX;
            tx_prev  = tx;
        end
    end

    // UART decoder on tx, sampling mid-bit
    initial begin : txdec
        logic [7:0] b;
        logic       prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !tx && dirTX) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                txq.push_back(b);
                prev = 1'b1;
            end else begin
                prev = tx;
            end
        end
    end

    task automatic clear_mon();
        rv_cnt = 0; fe_cnt = 0; es_cnt = 0; tx_falls = 0;
        rise_seen = 0; fall_seen = 0;
        addr_q.delete(); txq.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop_bit;
        idle(CPB);
        rx = 1'b1;
    endtask

    task automatic send_pkt(input logic [7:0] a, c, p, s);
        @(negedge clk);
        send_byte(a, 1'b1);
        send_byte(c, 1'b1);
        send_byte(p, 1'b1);
        send_byte(s, 1'b1);
    endtask

    // Reference response: address, command, payload from memory, XOR of all preceding bytes
    task automatic build_expect(input logic [7:0] cmd, input logic [7:0] param);
        logic [7:0] cs, a;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(cmd);
        for (int k = 0; k < RB; k++) begin
            a = param + 8'(k);
            exp_q.push_back(mem[a]);
        end
        cs = 8'h00;
        foreach (exp_q[i]) cs ^= exp_q[i];
        exp_q.push_back(cs);
    endtask

    task automatic run_valid(input logic [7:0] cmd, input logic [7:0] param);
        logic [7:0] a;
        clear_mon();
        build_expect(cmd, param);
        send_pkt(8'hA5, cmd, param, 8'hA5 ^ cmd ^ param);
        for (int i = 0; i < 4000 && !fall_seen; i++) @(negedge clk);
        check("resp_done", fall_seen, 1);
        idle(20);
        check("req_valid_pulses", rv_cnt, 1);
        check("req_cmd", reqCmd, cmd);
        check("req_param", reqParam, param);
        check("err_sum_none", es_cnt, 0);
        check("turn_delay", rise_cyc - rv_cyc, 64);
        check("dir_tx_len", fall_cyc - rise_cyc, 32 + NB * 10 * CPB);
        check("busy_released", busy, 0);
        check("tx_byte_count", txq.size(), NB);
        for (int i = 0; i < NB && i < txq.size(); i++) check("tx_byte", txq[i], exp_q[i]);
        check("rd_count", addr_q.size(), RB);
        for (int k = 0; k < RB && k < addr_q.size(); k++) begin
            a = param + 8'(k);
            check("data_addr", addr_q[k], a);
        end
    endtask

    task automatic run_silent(input logic [7:0] a, c, p, s, input int exp_es);
        clear_mon();
        send_pkt(a, c, p, s);
        idle(400);
        check("silent_no_valid", rv_cnt, 0);
        check("silent_err_sum", es_cnt, exp_es);
        check("silent_no_dir", rise_seen, 0);
        check("silent_no_tx", tx_falls, 0);
    endtask

    initial begin
        logic [7:0] c, p, a, bad;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        rx  = 1'b1;
        rst = 1'b1;
        clear_mon();
        idle(5);
        check("rst_tx", tx, 1);
        check("rst_dir_tx", dirTX, 0);
        check("rst_dir_rx", dirRX, 0);
        check("rst_busy", busy, 0);
        check("rst_req_cmd", reqCmd, 0);
        check("rst_data_addr", dataAddr, 0);
        rst = 1'b0;
        idle(10);

        run_valid(8'h01, 8'h07);
        for (int n = 0; n < 3; n++) run_valid(8'($urandom), 8'($urandom));

        // Bad checksum for our address, then foreign address with good checksum
        run_silent(8'hA5, 8'h01, 8'h07, 8'h00, 1);
        for (int n = 0; n < 2; n++) begin
            c   = 8'($urandom);
            p   = 8'($urandom);
            bad = 8'($urandom_range(1, 255));
            run_silent(8'hA5, c, p, 8'hA5 ^ c ^ p ^ bad, 1);
        end
        run_silent(8'h5A, 8'h01, 8'h07, 8'h5C, 0);
        a = 8'($urandom);
        if (a == 8'hA5) a = 8'h00;
        c = 8'($urandom);
        p = 8'($urandom);
        run_silent(a, c, p, a ^ c ^ p, 0);

        // Framing error, then a normal request
        clear_mon();
        @(negedge clk);
        send_byte(8'($urandom), 1'b0);
        idle(40);
        check("frame_err_pulse", fe_cnt, 1);
        check("frame_err_no_valid", rv_cnt, 0);
        run_valid(8'($urandom), 8'($urandom));

        // Short low glitch must not be taken as a byte
        @(negedge clk);
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(40);
        run_valid(8'h22, 8'h33);

        // Partial request aborted by inter-byte gap
        clear_mon();
        @(negedge clk);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        idle(400);
        send_byte(8'h07, 1'b1);
        send_byte(8'hA3, 1'b1);
        idle(400);
        check("gap_no_valid", rv_cnt, 0);
        check("gap_no_err", es_cnt, 0);
        check("gap_no_dir", rise_seen, 0);
        run_valid(8'h01, 8'h07);

        // Address wrap, then reset in the middle of the payload
        run_valid(8'($urandom), 8'hFE);
        clear_mon();
        send_pkt(8'hA5, 8'h10, 8'hFE, 8'hA5 ^ 8'h10 ^ 8'hFE);
        for (int i = 0; i < 3000 && txq.size() < 3; i++) @(negedge clk);
        check("reached_payload", txq.size() >= 3, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_dir_tx", dirTX, 0);
        check("mid_rst_dir_rx", dirRX, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_req_cmd", reqCmd, 0);
        idle(3);
        rst = 1'b0;
        idle(20);
        check("post_rst_idle", dirTX, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcb_responder.md
Name: lcb_responder

Overview:
- RS-485 UART slave that emulates one LCB channel on the far end of the telemetry request link.
- Receives the 4-byte request packet issued by the orbit-frame master, validates it, and answers with a response packet. Response payload is fetched from an external 1-cycle-latency data ROM/RAM.
- Used in the LCB emulator and in loop-back benches for the receive/packer chain.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per UART bit; even, >= 8.
- DEV_ADDR, 8'hA5: device address this responder answers to.
- RESP_BYTES, 4: payload bytes per response; range 1..16.
- TURN_CLKS, 64: clk cycles from reqValid to dirTX assertion.
- GAP_CLKS, 320: idle cycles after a stop bit that abort a partial request.

Ports:
- clk  in  1  system clock (80 MHz)
- rst  in  1  asynchronous, active-high reset
- rx  in  1  serial request line, idle high, asynchronous to clk
- tx  out  1  serial response line, idle high
- dirTX  out  1  RS-485 driver enable, 1 = driving
- dirRX  out  1  RS-485 receiver disable, 1 = receiver off
- dataAddr  out  8  payload read address
- dataRd  out  1  payload read strobe, 1 cycle
- dataIn  in  8  payload data, valid 1 cycle after dataRd
- reqValid  out  1  1-cycle pulse on an accepted request
- reqCmd  out  8  command byte of the last accepted request
- reqParam  out  8  parameter byte of the last accepted request
- errFrame  out  1  1-cycle pulse on a stop-bit error
- errSum  out  1  1-cycle pulse on a checksum mismatch for DEV_ADDR
- busy  out  1  high from reqValid until dirTX is released

Behaviour:
- Reset (async): tx=1; dirTX=0; dirRX=0; dataRd=0; dataAddr=0; reqValid=0; reqCmd=0; reqParam=0; errFrame=0; errSum=0; busy=0. All FSMs return to IDLE and the byte index is cleared. A reset mid-operation aborts any transfer immediately.
- rx path
  - rx passes through a 2-FF synchroniser.
  - A falling edge starts a byte. Re-sample at CLKS_PER_BIT/2; if high, treat as a glitch and return to IDLE.
  - 8 data bits are taken LSB first at mid-bit. The stop bit is sampled at mid-bit.
  - Stop bit = 0: pulse errFrame, drop the byte, reset the packet index to 0.
- Packet assembly
  - Byte order: b0 = addr, b1 = cmd, b2 = param, b3 = checksum.
  - A gap counter runs after each stop bit while the index is nonzero. Reaching GAP_CLKS resets the index to 0, with no error pulse.
  - On b3:
    - b0 != DEV_ADDR: silently discard.
    - b3 != b0^b1^b2: pulse errSum, discard.
    - Otherwise, in the cycle after b3's stop sample: reqValid=1, reqCmd=b1, reqParam=b2 (held until the next accept), busy=1.
- Response FSM
  - States: IDLE -> TURN -> GUARD -> SEND -> HOLD -> IDLE.
  - TURN: count TURN_CLKS, then dirTX=1 and dirRX=1.
  - GUARD: one bit time with tx=1.
  - SEND: transmit back to back DEV_ADDR, reqCmd, RESP_BYTES payload bytes, then checksum. Each byte is 1 start bit, 8 data bits LSB first, 1 stop bit, with no inter-byte gap.
  - Payload byte k (0-based): dataAddr = reqParam + k, mod 256 (wraps 8'hFF -> 8'h00). dataRd is pulsed at least 2 cycles before that byte's start bit; dataIn is latched the cycle after dataRd.
  - Checksum = XOR of every preceding response byte.
  - HOLD: one bit time after the last stop bit, then dirTX=0, dirRX=0, busy=0.
- Receiver gating
  - While dirRX=1, rx is ignored and the packet index is held at 0.
  - Requests arriving during TURN are still received but not acted on: no reqValid while busy. Such a packet is dropped silently and errSum never fires for it.
- Response length = (RESP_BYTES+3)*10*CLKS_PER_BIT cycles, plus GUARD and HOLD.

Test Plan:
- Request A5 01 07 A3 at 16 clk/bit -> reqValid pulse, reqCmd=01, reqParam=07. dirTX rises 64 clk later. tx carries A5 01 d0..d3 cs, with dataAddr 07,08,09,0A. dirTX falls 16 clk after the last stop bit.
- Request A5 01 07 00 (bad checksum) -> errSum pulse; no reqValid; dirTX stays 0.
- Request 5A 01 07 5C (other address) -> no reqValid, no errSum, no tx activity.
- Byte with stop bit forced 0 -> errFrame pulse. A following valid 4-byte request is accepted normally.
- Send A5 01, idle 400 clk, then 07 A3 -> partial packet discarded; no reqValid. The next full request is accepted.
- reqParam=FE with RESP_BYTES=4 -> dataAddr sequence FE,FF,00,01. Assert rst during the payload -> tx=1, dirTX=0 and busy=0 within the reset assertion.
